art_input_debounce: RTL and testbench

- Input conditioning stage that sits directly upstream of the silicon-art top-level output logic.
- Takes the raw dedicated input pins, which are asynchronous and may bounce because they come from switches.
- Synchronises and debounces each bit, then presents a stable byte plus a change strobe to the top-level output XOR stage.
- Keeps the logic small and fully registered so the art area stays free.

---
 rtl/art_pkg.sv | 14 +
 rtl/art_debounce_bit.sv | 66 ++++++
 rtl/art_input_debounce.sv | 85 ++++++++
 tb/tb_art_input_debounce.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/art_pkg.sv
// Shared constants for the silicon-art input conditioning path.
package art_pkg;

  localparam int ART_IO_WIDTH     = 8;
  localparam int ART_SYNC_STAGES  = 2;
  localparam int ART_PRESCALE     = 1000;
  localparam int ART_STABLE_TICKS = 4;

  // Width of a counter that must hold 0..n-1, never narrower than one bit.
  function automatic int art_cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/art_debounce_bit.sv
// One input bit: synchroniser chain, stability counter and the debounced output flop.
module art_debounce_bit
  import art_pkg::*;
#(
  parameter int   SYNC_STAGES  = ART_SYNC_STAGES,
  parameter int   STABLE_TICKS = ART_STABLE_TICKS,
  parameter logic RESET_VALUE  = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic din,
  output logic dout,
  output logic flip
);

  localparam int CNT_W = $clog2(STABLE_TICKS) + 1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;
  logic                   dout_q;
  logic                   dout_d;
  logic                   sync_s;
  logic                   flip_s;

  assign sync_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    cnt_d  = cnt_q;
    dout_d = dout_q;
    flip_s = 1'b0;
    if (tick) begin
      if (sync_s == dout_q) begin
        cnt_d = {CNT_W{1'b0}};
      end else if (cnt_q == CNT_W'(STABLE_TICKS - 1)) begin
        // The new level has persisted long enough: accept it.
        dout_d = ~dout_q;
        cnt_d  = {CNT_W{1'b0}};
        flip_s = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{1'b0}};
      cnt_q  <= {CNT_W{1'b0}};
      dout_q <= RESET_VALUE;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;
  assign flip = flip_s;

endmodule

// File: rtl/art_input_debounce.sv
// Debounces the raw input pins into a stable byte plus a registered change strobe and mask.
module art_input_debounce
  import art_pkg::*;
#(
  parameter int               WIDTH        = ART_IO_WIDTH,
  parameter int               SYNC_STAGES  = ART_SYNC_STAGES,
  parameter int               PRESCALE     = ART_PRESCALE,
  parameter int               STABLE_TICKS = ART_STABLE_TICKS,
  parameter logic [WIDTH-1:0] RESET_VALUE  = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             changed,
  output logic [WIDTH-1:0] changed_mask
);

  localparam int PS_W = art_cnt_width(PRESCALE);

  logic [PS_W-1:0]  ps_q;
  logic [PS_W-1:0]  ps_d;
  logic             tick_s;
  logic [WIDTH-1:0] flip_s;
  logic             changed_q;
  logic             changed_d;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] mask_d;

  // Shared sample-tick prescaler; frozen along with tick while ena is low.
  always_comb begin
    tick_s = 1'b0;
    ps_d   = ps_q;
    if (ena) begin
      if (ps_q == PS_W'(PRESCALE - 1)) begin
        tick_s = 1'b1;
        ps_d   = {PS_W{1'b0}};
      end else begin
        ps_d = ps_q + PS_W'(1);
      end
    end else begin
      ps_d = ps_q;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      art_debounce_bit #(
        .SYNC_STAGES (SYNC_STAGES),
        .STABLE_TICKS(STABLE_TICKS),
        .RESET_VALUE (RESET_VALUE[gi])
      ) u_bit (
        .clk (clk),
        .rst (rst),
        .tick(tick_s),
        .din (din[gi]),
        .dout(dout[gi]),
        .flip(flip_s[gi])
      );
    end
  endgenerate

  always_comb begin
    mask_d    = flip_s;
    changed_d = |flip_s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ps_q      <= {PS_W{1'b0}};
      changed_q <= 1'b0;
      mask_q    <= {WIDTH{1'b0}};
    end else begin
      ps_q      <= ps_d;
      changed_q <= changed_d;
      mask_q    <= mask_d;
    end
  end

  assign changed      = changed_q;
  assign changed_mask = mask_q;

endmodule

// File: tb/tb_art_input_debounce.sv
// Scoreboard bench for art_input_debounce: expected change events are queued when din is driven.
module tb_art_input_debounce;

  typedef struct packed {
    logic [7:0]  dout;
    logic [7:0]  mask;
    logic [31:0] at_edge;
  } sb_item_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b1;
  logic [7:0] din = 8'h00;
  logic [7:0] dout;
  logic       changed;
  logic [7:0] changed_mask;
  logic [7:0] din6 = 8'h00;
  logic [7:0] dout6;
  logic       changed6;
  logic [7:0] changed_mask6;

  logic [31:0] edge_n;
  sb_item_t    sb_q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  art_input_debounce #(
    .WIDTH(8), .SYNC_STAGES(2), .PRESCALE(4), .STABLE_TICKS(3), .RESET_VALUE(8'h00)
  ) dut (
    .clk(clk), .rst(rst), .ena(ena), .din(din),
    .dout(dout), .changed(changed), .changed_mask(changed_mask)
  );

  art_input_debounce #(
    .WIDTH(8), .SYNC_STAGES(2), .PRESCALE(1), .STABLE_TICKS(1), .RESET_VALUE(8'h00)
  ) dut6 (
    .clk(clk), .rst(rst), .ena(ena), .din(din6),
    .dout(dout6), .changed(changed6), .changed_mask(changed_mask6)
  );

  always @(posedge clk or posedge rst) begin
    if (rst) edge_n <= 32'd0;
    else     edge_n <= edge_n + 32'd1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  // Monitor: every change pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    sb_item_t e;
    if (!rst) begin
      if (changed) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_changed", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("sb_edge", edge_n, e.at_edge);
          chk("sb_dout", {24'd0, dout}, {24'd0, e.dout});
          chk("sb_mask", {24'd0, changed_mask}, {24'd0, e.mask});
        end
      end else begin
        chk("mask_idle", {24'd0, changed_mask}, 32'd0);
      end
    end
  end

  task automatic apply_reset(input logic [7:0] d, input logic [7:0] d6);
    rst  = 1'b1;
    ena  = 1'b1;
    din  = d;
    din6 = d6;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_to(input int n);
    while (edge_n < 32'(n)) @(negedge clk);
  endtask

  task automatic push(input logic [7:0] d, input logic [7:0] m, input int e);
    sb_item_t it;
    it.dout    = d;
    it.mask    = m;
    it.at_edge = 32'(e);
    sb_q.push_back(it);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_dout", {24'd0, dout}, 32'd0);
    chk("rst_changed", {31'd0, changed}, 32'd0);
    chk("rst_mask", {24'd0, changed_mask}, 32'd0);

    // 1. Basic accept
    apply_reset(8'h01, 8'h00);
    push(8'h01, 8'h01, 12);
    wait_to(11);
    chk("s1_dout_e11", {24'd0, dout}, 32'h00);
    wait_to(12);
    chk("s1_dout_e12", {24'd0, dout}, 32'h01);
    chk("s1_changed_e12", {31'd0, changed}, 32'd1);
    wait_to(13);
    chk("s1_changed_e13", {31'd0, changed}, 32'd0);
    chk("s1_dout_e13", {24'd0, dout}, 32'h01);
    wait_to(20);
    chk("s1_sb_empty", 32'(sb_q.size()), 32'd0);

    // 2. Glitch reject
    apply_reset(8'h01, 8'h00);
    wait_to(6);
    din = 8'h00;
    wait_to(8);
    chk("s2_cnt_tick2", 32'(dut.g_bit[0].u_bit.cnt_q), 32'd2);
    wait_to(12);
    chk("s2_cnt_tick3", 32'(dut.g_bit[0].u_bit.cnt_q), 32'd0);
    wait_to(40);
    chk("s2_dout", {24'd0, dout}, 32'h00);
    chk("s2_sb_empty", 32'(sb_q.size()), 32'd0);

    // 3. Multi-bit
    apply_reset(8'hA5, 8'h00);
    push(8'hA5, 8'hA5, 12);
    wait_to(12);
    chk("s3_dout_a5", {24'd0, dout}, 32'hA5);
    din = 8'hA4;
    push(8'hA4, 8'h01, 24);
    wait_to(23);
    chk("s3_dout_e23", {24'd0, dout}, 32'hA5);
    wait_to(30);
    chk("s3_dout_a4", {24'd0, dout}, 32'hA4);
    chk("s3_sb_empty", 32'(sb_q.size()), 32'd0);

    // 4. Enable freeze across 8 edges (8..15)
    apply_reset(8'h01, 8'h00);
    push(8'h01, 8'h01, 20);
    wait_to(7);
    ena = 1'b0;
    wait_to(15);
    chk("s4_dout_e15", {24'd0, dout}, 32'h00);
    ena = 1'b1;
    wait_to(19);
    chk("s4_dout_e19", {24'd0, dout}, 32'h00);
    wait_to(20);
    chk("s4_dout_e20", {24'd0, dout}, 32'h01);
    wait_to(26);
    chk("s4_sb_empty", 32'(sb_q.size()), 32'd0);

    // 5. Reset mid-operation
    apply_reset(8'hFF, 8'h00);
    push(8'hFF, 8'hFF, 12);
    wait_to(12);
    chk("s5_dout_ff", {24'd0, dout}, 32'hFF);
    din = 8'h00;
    wait_to(20);
    chk("s5_dout_pre_rst", {24'd0, dout}, 32'hFF);
    rst = 1'b1;
    #1;
    chk("s5_dout_async", {24'd0, dout}, 32'h00);
    chk("s5_changed_async", {31'd0, changed}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_to(40);
    chk("s5_dout_after", {24'd0, dout}, 32'h00);
    chk("s5_sb_empty", 32'(sb_q.size()), 32'd0);

    // 6. PRESCALE=1, STABLE_TICKS=1 corner
    apply_reset(8'h00, 8'h80);
    wait_to(2);
    chk("s6_dout_e2", {24'd0, dout6}, 32'h00);
    wait_to(3);
    chk("s6_dout_e3", {24'd0, dout6}, 32'h80);
    chk("s6_changed_e3", {31'd0, changed6}, 32'd1);
    chk("s6_mask_e3", {24'd0, changed_mask6}, 32'h80);
    wait_to(4);
    chk("s6_changed_e4", {31'd0, changed6}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
